// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: RF read addressing, operand bypass,
// load-use bubble insertion and a saturating bubble counter.
module id_ex_stage #(
    parameter int DSIZE  = 16,
    parameter int RSIZE  = 4,
    parameter int OPSIZE = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              id_valid,
    input  logic [OPSIZE-1:0] id_opcode,
    input  logic [RSIZE-1:0]  id_rs1,
    input  logic [RSIZE-1:0]  id_rs2,
    input  logic [RSIZE-1:0]  id_rd,
    input  logic [DSIZE-1:0]  id_imm,
    input  logic              id_use_imm,
    input  logic              id_wen,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    output logic [RSIZE-1:0]  RAddr1,
    output logic [RSIZE-1:0]  RAddr2,
    input  logic [DSIZE-1:0]  RData1,
    input  logic [DSIZE-1:0]  RData2,
    input  logic [DSIZE-1:0]  ex_alu_result,
    input  logic              mem_wen,
    input  logic [RSIZE-1:0]  mem_rd,
    input  logic [DSIZE-1:0]  mem_data,
    input  logic              wb_wen,
    input  logic [RSIZE-1:0]  wb_rd,
    input  logic [DSIZE-1:0]  wb_data,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_wen,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [OPSIZE-1:0] ex_opcode,
    output logic [RSIZE-1:0]  ex_rd,
    output logic [DSIZE-1:0]  ex_opA,
    output logic [DSIZE-1:0]  ex_opB,
    output logic [DSIZE-1:0]  ex_store_data,
    output logic [15:0]       stall_count
);

    logic [DSIZE-1:0] fwd1;
    logic [DSIZE-1:0] fwd2;
    logic             uses_rs2;
    logic             lu;

    assign RAddr1 = id_rs1;
    assign RAddr2 = id_rs2;

    // Youngest producer wins; WB beats the RF because the RF write lands at the edge.
    always_comb begin
        fwd1 = RData1;
        if (id_rs1 == '0)
            fwd1 = '0;
        else if (ex_valid && ex_wen && ex_rd == id_rs1)
            fwd1 = ex_alu_result;
        else if (mem_wen && mem_rd == id_rs1)
            fwd1 = mem_data;
        else if (wb_wen && wb_rd == id_rs1)
            fwd1 = wb_data;
    end

    always_comb begin
        fwd2 = RData2;
        if (id_rs2 == '0)
            fwd2 = '0;
        else if (ex_valid && ex_wen && ex_rd == id_rs2)
            fwd2 = ex_alu_result;
        else if (mem_wen && mem_rd == id_rs2)
            fwd2 = mem_data;
        else if (wb_wen && wb_rd == id_rs2)
            fwd2 = wb_data;
    end

    assign uses_rs2 = !id_use_imm || id_mem_write;

    assign lu = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (uses_rs2 && ex_rd == id_rs2));

    assign stall = Reset && (hold || (lu && !flush));

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ex_valid      <= 1'b0;
            ex_wen        <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_opcode     <= '0;
            ex_rd         <= '0;
            ex_opA        <= '0;
            ex_opB        <= '0;
            ex_store_data <= '0;
            stall_count   <= '0;
        end else if (hold) begin
            ex_valid <= ex_valid;
        end else if (flush || lu) begin
            ex_valid     <= 1'b0;
            ex_wen       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            if (!flush && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end else begin
            ex_valid      <= id_valid;
            ex_wen        <= id_valid & id_wen & (id_rd != '0);
            ex_mem_read   <= id_valid & id_mem_read;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_opcode     <= id_opcode;
            ex_rd         <= id_rd;
            ex_opA        <= fwd1;
            ex_opB        <= id_use_imm ? id_imm : fwd2;
            ex_store_data <= fwd2;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass priority, load-use
// bubbles, flush/hold interaction and counter saturation.
module tb_id_ex_stage;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rs1, id_rs2, id_rd;
    logic [15:0] id_imm;
    logic        id_use_imm, id_wen, id_mem_read, id_mem_write;
    logic [3:0]  RAddr1, RAddr2;
    logic [15:0] RData1, RData2;
    logic [15:0] ex_alu_result;
    logic        mem_wen;
    logic [3:0]  mem_rd;
    logic [15:0] mem_data;
    logic        wb_wen;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        hold, flush;
    logic        stall;
    logic        ex_valid, ex_wen, ex_mem_read, ex_mem_write;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_rd;
    logic [15:0] ex_opA, ex_opB, ex_store_data;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    id_ex_stage dut (
        .Clock(Clock), .Reset(Reset),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_wen(id_wen), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write),
        .RAddr1(RAddr1), .RAddr2(RAddr2),
        .RData1(RData1), .RData2(RData2),
        .ex_alu_result(ex_alu_result),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .hold(hold), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_wen(ex_wen),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .ex_opA(ex_opA), .ex_opB(ex_opB),
        .ex_store_data(ex_store_data), .stall_count(stall_count)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_opcode = 0; id_rs1 = 0; id_rs2 = 0;
        id_rd = 0; id_imm = 0; id_use_imm = 0; id_wen = 0;
        id_mem_read = 0; id_mem_write = 0;
        RData1 = 0; RData2 = 0; ex_alu_result = 0;
        mem_wen = 0; mem_rd = 0; mem_data = 0;
        wb_wen = 0; wb_rd = 0; wb_data = 0;
        hold = 0; flush = 0;
    endtask

    task automatic load_r4();
        idle();
        id_valid = 1; id_opcode = 4'hA; id_rd = 4;
        id_wen = 1; id_mem_read = 1;
        step();
    endtask

    task automatic test_reset();
        Reset = 0;
        id_valid = 1; id_opcode = 4'h7; id_rs1 = 3; id_rs2 = 4;
        id_rd = 5; id_imm = 16'h1357; id_use_imm = 0; id_wen = 1;
        id_mem_read = 1; id_mem_write = 1;
        RData1 = 16'hAAAA; RData2 = 16'h5555; ex_alu_result = 16'h9999;
        mem_wen = 1; mem_rd = 3; mem_data = 16'h7777;
        wb_wen = 1; wb_rd = 4; wb_data = 16'h6666;
        hold = 1; flush = 0;
        step();
        step();
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall got=%b want=0", stall);
        end
        total++;
        if ({ex_valid, ex_wen, ex_mem_read, ex_mem_write} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000",
                {ex_valid, ex_wen, ex_mem_read, ex_mem_write});
        end
        total++;
        if ({ex_opcode, ex_rd, ex_opA, ex_opB, ex_store_data} !== '0) begin
            bad++;
            $display("FAIL reset_data op=%h rd=%h a=%h b=%h s=%h want=0",
                ex_opcode, ex_rd, ex_opA, ex_opB, ex_store_data);
        end
        total++;
        if (stall_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_count got=%h want=0000", stall_count);
        end
        idle();
        Reset = 1;
    endtask

    task automatic test_ex_bypass();
        idle();
        id_valid = 1; id_opcode = 4'h1; id_rd = 3; id_wen = 1;
        step();
        id_rd = 6; id_rs1 = 3; RData1 = 16'h0000;
        ex_alu_result = 16'h0042;
        total++;
        if (RAddr1 !== 4'd3) begin
            bad++;
            $display("FAIL raddr1 got=%h want=3", RAddr1);
        end
        step();
        total++;
        if (ex_opA !== 16'h0042) begin
            bad++;
            $display("FAIL ex_bypass got=%h want=0042", ex_opA);
        end
        total++;
        if (ex_rd !== 4'd6 || ex_wen !== 1'b1 || ex_valid !== 1'b1) begin
            bad++;
            $display("FAIL ex_bypass_ctrl rd=%h wen=%b v=%b want=6/1/1",
                ex_rd, ex_wen, ex_valid);
        end
    endtask

    task automatic test_priority();
        idle();
        id_valid = 1; id_opcode = 4'h1; id_rd = 5; id_wen = 1;
        step();
        id_rd = 7; id_rs1 = 5;
        ex_alu_result = 16'h1111;
        mem_wen = 1; mem_rd = 5; mem_data = 16'h2222;
        wb_wen = 1; wb_rd = 5; wb_data = 16'h3333;
        RData1 = 16'h4444; RData2 = 16'h4444;
        step();
        total++;
        if (ex_opA !== 16'h1111) begin
            bad++;
            $display("FAIL prio_ex got=%h want=1111", ex_opA);
        end
        id_rs2 = 5; id_use_imm = 1; id_imm = 16'h00AB;
        step();
        total++;
        if (ex_opA !== 16'h2222) begin
            bad++;
            $display("FAIL prio_mem got=%h want=2222", ex_opA);
        end
        total++;
        if (ex_opB !== 16'h00AB || ex_store_data !== 16'h2222) begin
            bad++;
            $display("FAIL prio_imm b=%h s=%h want=00ab/2222",
                ex_opB, ex_store_data);
        end
        mem_wen = 0; id_use_imm = 0;
        step();
        total++;
        if (ex_opA !== 16'h3333 || ex_opB !== 16'h3333) begin
            bad++;
            $display("FAIL prio_wb a=%h b=%h want=3333", ex_opA, ex_opB);
        end
        wb_wen = 0;
        step();
        total++;
        if (ex_opA !== 16'h4444) begin
            bad++;
            $display("FAIL prio_rf got=%h want=4444", ex_opA);
        end
        id_rs1 = 0; wb_wen = 1; wb_rd = 0; wb_data = 16'hFFFF;
        RData1 = 16'h1234;
        step();
        total++;
        if (ex_opA !== 16'h0000) begin
            bad++;
            $display("FAIL prio_r0 got=%h want=0000", ex_opA);
        end
    endtask

    task automatic test_load_use();
        load_r4();
        id_mem_read = 0; id_opcode = 4'h2;
        id_rs1 = 1; id_rs2 = 4; id_rd = 2; id_wen = 1;
        RData2 = 16'h1234;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall got=%b want=1", stall);
        end
        step();
        total++;
        if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || stall_count !== 16'd1) begin
            bad++;
            $display("FAIL lu_bubble v=%b mr=%b cnt=%h want=0/0/0001",
                ex_valid, ex_mem_read, stall_count);
        end
        mem_wen = 1; mem_rd = 4; mem_data = 16'hBEEF;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL lu_release got=%b want=0", stall);
        end
        step();
        total++;
        if (ex_opB !== 16'hBEEF || ex_valid !== 1'b1 || ex_rd !== 4'd2) begin
            bad++;
            $display("FAIL lu_mem_fwd b=%h v=%b rd=%h want=beef/1/2",
                ex_opB, ex_valid, ex_rd);
        end
    endtask

    task automatic test_no_false_hazard();
        load_r4();
        id_mem_read = 0; id_rd = 2; id_rs1 = 0; id_rs2 = 4;
        id_use_imm = 1; id_imm = 16'h0005;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL nofalse_stall got=%b want=0", stall);
        end
        step();
        total++;
        if (ex_valid !== 1'b1 || ex_opB !== 16'h0005 || stall_count !== 16'd1) begin
            bad++;
            $display("FAIL nofalse_reg v=%b b=%h cnt=%h want=1/0005/0001",
                ex_valid, ex_opB, stall_count);
        end
    endtask

    task automatic test_flush_vs_hazard();
        load_r4();
        id_mem_read = 0; id_wen = 0; id_rs2 = 4;
        id_use_imm = 1; id_mem_write = 1;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL store_hazard got=%b want=1", stall);
        end
        flush = 1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall got=%b want=0", stall);
        end
        step();
        total++;
        if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || stall_count !== 16'd1) begin
            bad++;
            $display("FAIL flush_bubble v=%b mw=%b cnt=%h want=0/0/0001",
                ex_valid, ex_mem_write, stall_count);
        end
    endtask

    task automatic test_hold();
        idle();
        id_valid = 1; id_opcode = 4'h9; id_rd = 3; id_wen = 1;
        step();
        hold = 1;
        id_opcode = 4'h2; id_rd = 8;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL hold_stall got=%b want=1", stall);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (ex_opcode !== 4'h9 || ex_rd !== 4'd3 || ex_valid !== 1'b1 ||
                stall_count !== 16'd1) begin
                bad++;
                $display("FAIL hold_frozen%0d op=%h rd=%h v=%b cnt=%h want=9/3/1/0001",
                    i, ex_opcode, ex_rd, ex_valid, stall_count);
            end
        end
        hold = 0;
        step();
        total++;
        if (ex_opcode !== 4'h2 || ex_rd !== 4'd8) begin
            bad++;
            $display("FAIL hold_release op=%h rd=%h want=2/8", ex_opcode, ex_rd);
        end
    endtask

    task automatic test_reset_mid_stall();
        load_r4();
        id_mem_read = 0; id_rs1 = 4; id_rd = 2;
        Reset = 0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_stall got=%b want=0", stall);
        end
        step();
        total++;
        if (ex_valid !== 1'b0 || ex_rd !== 4'd0 || stall_count !== 16'd0) begin
            bad++;
            $display("FAIL rst_mid_clear v=%b rd=%h cnt=%h want=0/0/0000",
                ex_valid, ex_rd, stall_count);
        end
        Reset = 1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_first_cycle got=%b want=0", stall);
        end
    endtask

    task automatic test_saturation();
        idle();
        id_valid = 1; id_opcode = 4'hA; id_rd = 4; id_rs1 = 4;
        id_wen = 1; id_mem_read = 1;
        for (int i = 0; i < 2 * 65537 + 4; i++)
            step();
        total++;
        if (stall_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL saturate got=%h want=ffff", stall_count);
        end
        step();
        step();
        total++;
        if (stall_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL saturate_hold got=%h want=ffff", stall_count);
        end
    endtask

    initial begin
        idle();
        Reset = 0;
        test_reset();
        test_ex_bypass();
        test_priority();
        test_load_use();
        test_no_false_hazard();
        test_flush_vs_hazard();
        test_hold();
        test_reset_mid_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage placed directly after the register file read ports.
- Drives RF read addresses from the decoded instruction and resolves operands by bypassing over stale RF data.
- Detects load-use hazards and inserts bubbles, then registers operands and control for the EX stage.
- Also produces the stall request to IF/ID and a saturating stall counter.

Parameters:
DSIZE, 16, data width (matches RF word)
RSIZE, 4, register address width (16 registers, r0 hardwired zero)
OPSIZE, 4, opcode width

Ports:
Clock  input  1  clock, rising edge
Reset  input  1  synchronous, active-low
id_valid  input  1  decoded instruction present
id_opcode  input  OPSIZE  decoded opcode
id_rs1, id_rs2, id_rd  input  RSIZE  source/dest register numbers
id_imm  input  DSIZE  sign-extended immediate
id_use_imm  input  1  operand B = immediate
id_wen, id_mem_read, id_mem_write  input  1  decoded control
RAddr1, RAddr2  output  RSIZE  RF read addresses (combinational = id_rs1/id_rs2)
RData1, RData2  input  DSIZE  RF read data (combinational)
ex_alu_result  input  DSIZE  ALU output of instruction now in EX
mem_wen  input  1  MEM-stage instr writes a register
mem_rd  input  RSIZE  MEM-stage dest
mem_data  input  DSIZE  MEM-stage result (load data included)
wb_wen  input  1  RF write enable this cycle
wb_rd  input  RSIZE  RF write address
wb_data  input  DSIZE  RF write data
hold  input  1  downstream freeze
flush  input  1  kill ID instruction (taken branch)
stall  output  1  hold IF/ID (combinational)
ex_valid, ex_wen, ex_mem_read, ex_mem_write  output  1  registered control
ex_opcode  output  OPSIZE  registered opcode
ex_rd  output  RSIZE  registered dest
ex_opA, ex_opB, ex_store_data  output  DSIZE  registered operands
stall_count  output  16  saturating count of bubble cycles

Behaviour:
- Reset=0 at rising edge: all ex_* outputs and stall_count are 0. stall is 0 while Reset=0.
- Operand resolution (combinational) for each source rsN, first match wins:
  - rsN==0 -> 0.
  - ex_valid && ex_wen && ex_rd==rsN -> ex_alu_result.
  - mem_wen && mem_rd==rsN -> mem_data.
  - wb_wen && wb_rd==rsN -> wb_data (the RF updates only at the edge, so its read is stale this cycle).
  - otherwise -> RDataN.
- uses_rs2 = !id_use_imm || id_mem_write.
- Load-use hazard: lu = id_valid && ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (uses_rs2 && ex_rd==id_rs2)).
- stall = hold || (lu && !flush).
- Register update at each edge, Reset first, then first true condition:
  - hold: all ex_* outputs keep their values.
  - flush: bubble (ex_valid, ex_wen, ex_mem_read, ex_mem_write = 0; data fields keep their values).
  - lu: bubble; stall_count increments, saturating at 16'hFFFF.
  - normal:
    - ex_valid <= id_valid.
    - ex_wen <= id_valid & id_wen & (id_rd!=0).
    - ex_mem_read/write <= id_valid & id_mem_*.
    - ex_opA <= fwd1; ex_opB <= id_use_imm ? id_imm : fwd2; ex_store_data <= fwd2.
    - ex_opcode, ex_rd registered.
- Hazard timing:
  - A load followed immediately by a dependent instruction costs exactly 1 bubble.
  - On the following cycle the load is in MEM and the operand is taken from mem_data.
- Invalid ID (id_valid=0) never raises lu and produces a bubble.
- hold does not increment stall_count.
- Reset mid-stall clears everything the same cycle. The first cycle after reset has no hazard.

Test Plan:
- Reset: Reset=0 for 2 cycles with arbitrary inputs -> all ex_* = 0, stall_count=0, stall=0.
- EX bypass: ex holds ADD r3 (ex_alu_result=16'h0042); ID reads r3, RData1=16'h0000 -> ex_opA=16'h0042 next edge.
- Priority: EX r5=16'h1111, MEM r5=16'h2222, WB r5=16'h3333, RF=16'h4444 -> ex_opA=16'h1111. Drop EX -> 16'h2222. Drop MEM -> 16'h3333. Read of r0 with WB r0=16'hFFFF -> 0.
- Load-use: LD r4 in EX, ID uses r4 as rs2 (use_imm=0) -> stall=1, one bubble, stall_count=1. Next cycle mem_data=16'hBEEF forwarded -> ex_opB=16'hBEEF, stall=0.
- No false hazard: LD r4 in EX, ID ADDI r2,r4?no: rs2=r4 with id_use_imm=1, id_mem_write=0 -> no stall.
- Flush vs hazard: lu and flush in the same cycle -> stall=0, bubble, stall_count unchanged.
- Hold: hold=1 for 3 cycles -> ex_* frozen, stall=1, stall_count unchanged.
- Saturation: drive 65537 load-use cycles -> stall_count=16'hFFFF.
